// File: rtl/forwarding_scoreboard_pkg.sv
// Shared SPU pipeline definitions: forwarding select encodings, scoreboard
// sizing defaults and the in-flight producer slot record.
package forwarding_scoreboard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int DEPTH_DEFAULT   = 8;
  localparam int MAX_LAT_DEFAULT = 6;

  typedef struct packed {
    logic       valid;
    logic [6:0] rt;
    logic [2:0] lat;
  } slot_t;

  // A zero latency is treated as one cycle; anything past the pipeline's
  // deepest producer is pinned to that maximum.
  function automatic logic [2:0] clamp_lat(input logic [2:0] lat, input logic [2:0] max_lat);
    if (lat == 3'd0)
      return 3'd1;
    if (lat > max_lat)
      return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_src_hazard_check.sv
// Per-source hazard check: finds the youngest in-flight producer of src and
// classifies it as not-ready, MEM-forward, WB-forward or regfile.
module src_hazard_check
  import forwarding_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [6:0]        src,
  input  logic              use_src,
  output logic [1:0]        sel,
  output logic              not_ready
);

  logic hit;
  int   age;
  int   lat;

  always_comb begin
    hit = 1'b0;
    age = 0;
    lat = 0;
    // Scan oldest to youngest so the youngest matching producer wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].rt == src)) begin
        hit = 1'b1;
        age = k + 1;
        lat = int'(slots[k].lat);
      end
    end

    sel       = FWD_RF;
    not_ready = 1'b0;
    if (use_src && hit) begin
      if (age < lat)
        not_ready = 1'b1;
      else if (age == lat)
        sel = FWD_MEM;
      else if (age == lat + 1)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers by age and drives
// operand forwarding selects and the decode stall for the issuing instruction.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int MAX_LAT = MAX_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_writes,
  input  logic [6:0]  issue_rt,
  input  logic [2:0]  issue_lat,
  input  logic [6:0]  src_a,
  input  logic [6:0]  src_b,
  input  logic [6:0]  src_c,
  input  logic        use_a,
  input  logic        use_b,
  input  logic        use_c,
  input  logic        flush,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic [1:0]  fwd_sel_c,
  output logic        stall,
  output logic [15:0] stall_count
);

  logic [DEPTH-1:0]      slot_vld;
  logic [DEPTH-1:0][6:0] slot_rt;
  logic [DEPTH-1:0][2:0] slot_lat;
  slot_t [DEPTH-1:0]     slots;

  logic [1:0] sel_a, sel_b, sel_c;
  logic       nr_a, nr_b, nr_c;
  logic       load_vld;

  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      slots[k] = {slot_vld[k], slot_rt[k], slot_lat[k]};
  end

  src_hazard_check #(.DEPTH(DEPTH)) u_chk_a (
    .slots(slots), .src(src_a), .use_src(use_a), .sel(sel_a), .not_ready(nr_a)
  );
  src_hazard_check #(.DEPTH(DEPTH)) u_chk_b (
    .slots(slots), .src(src_b), .use_src(use_b), .sel(sel_b), .not_ready(nr_b)
  );
  src_hazard_check #(.DEPTH(DEPTH)) u_chk_c (
    .slots(slots), .src(src_c), .use_src(use_c), .sel(sel_c), .not_ready(nr_c)
  );

  assign stall     = issue_valid & ~flush & (nr_a | nr_b | nr_c);
  assign fwd_sel_a = flush ? FWD_RF : sel_a;
  assign fwd_sel_b = flush ? FWD_RF : sel_b;
  assign fwd_sel_c = flush ? FWD_RF : sel_c;
  assign load_vld  = issue_valid & issue_writes & ~stall & ~flush;

  // Slot shift: slot 0 holds age 1; a stalled or flushed cycle inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld    <= '0;
      stall_count <= '0;
    end else begin
      slot_vld <= {slot_vld[DEPTH-2:0], load_vld};
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    slot_rt  <= {slot_rt[DEPTH-2:0], issue_rt};
    slot_lat <= {slot_lat[DEPTH-2:0], clamp_lat(issue_lat, 3'(MAX_LAT))};
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard bench for forwarding_scoreboard: directed issue sequences push
// expected outputs; a negedge monitor pops and compares them.
module tb_forwarding_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid, issue_writes, use_a, use_b, use_c, flush;
  logic [6:0]  issue_rt, src_a, src_b, src_c;
  logic [2:0]  issue_lat;
  logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_c;
  logic        stall;
  logic [15:0] stall_count;

  typedef struct {
    string       name;
    logic [6:0]  outs;
    logic [6:0]  mask;
    bit          chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  forwarding_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_rt(issue_rt), .issue_lat(issue_lat),
    .src_a(src_a), .src_b(src_b), .src_c(src_c),
    .use_a(use_a), .use_b(use_b), .use_c(use_c),
    .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_sel_c(fwd_sel_c),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 0; issue_writes = 0; issue_rt = 0; issue_lat = 0;
    src_a = 0; src_b = 0; src_c = 0;
    use_a = 0; use_b = 0; use_c = 0; flush = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue_wr(input logic [6:0] rt, input logic [2:0] lat);
    issue_valid = 1; issue_writes = 1; issue_rt = rt; issue_lat = lat;
  endtask

  // dca: sel_a is a don't-care (source not ready, select unspecified)
  task automatic expect_out(input string n, input logic st, input logic [1:0] a, b, c,
                            input bit dca = 0, input bit cc = 0, input logic [15:0] cv = 16'h0);
    exp_t e;
    e.name = n; e.outs = {st, a, b, c};
    e.mask = dca ? 7'b1001111 : 7'b1111111;
    e.chk_cnt = cc; e.cnt = cv;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if ((({stall, fwd_sel_a, fwd_sel_b, fwd_sel_c}) & mon_e.mask) !== (mon_e.outs & mon_e.mask)) begin
        errors++;
        $display("FAIL %s: stall_sa_sb_sc got %b_%b_%b_%b want %b (mask %b)", mon_e.name,
                 stall, fwd_sel_a, fwd_sel_b, fwd_sel_c, mon_e.outs, mon_e.mask);
      end
      if (mon_e.chk_cnt) begin
        checks++;
        if (stall_count !== mon_e.cnt) begin
          errors++;
          $display("FAIL %s_cnt: stall_count got %h want %h", mon_e.name, stall_count, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    idle();
    #1 reset = 1;
    nxt();
    reset = 1; use_a = 1;
    expect_out("rst_hold", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h0);
    nxt();
    reset = 0; use_a = 1; use_b = 1; use_c = 1;
    expect_out("post_rst", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h0);

    // RAW on rt=5, latency 2: age 1 stalls, age 2 forwards from MEM
    nxt(); issue_wr(7'd5, 3'd2);
    expect_out("t1_issue", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd5;
    expect_out("t1_stall", 1, 2'b00, 2'b00, 2'b00, 1);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd5;
    expect_out("t1_mem", 0, 2'b01, 2'b00, 2'b00);
    nxt();
    expect_out("t1_cnt", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'd1);

    // rt=9 lat 1 read after two gaps -> regfile; rt=10 after one gap -> WB
    nxt(); issue_wr(7'd9, 3'd1);
    expect_out("t2_i9", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_wr(7'd20, 3'd1);
    expect_out("t2_i20", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_wr(7'd21, 3'd1);
    expect_out("t2_i21", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_b = 1; src_b = 7'd9; use_a = 1; src_a = 7'd21;
    expect_out("t2_rf", 0, 2'b01, 2'b00, 2'b00);
    nxt(); issue_wr(7'd10, 3'd1);
    expect_out("t2_i10", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_wr(7'd22, 3'd1);
    expect_out("t2_i22", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_b = 1; src_b = 7'd10;
    expect_out("t2_wb", 0, 2'b00, 2'b10, 2'b00);

    // Two writers of rt=3: the younger lat-1 producer wins
    nxt(); issue_wr(7'd3, 3'd6);
    expect_out("t3_old", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_wr(7'd3, 3'd1);
    expect_out("t3_young", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_c = 1; src_c = 7'd3;
    expect_out("t3_youngest", 0, 2'b00, 2'b00, 2'b01);

    // Flush masks a pending stall and must not load its own write of rt=31
    nxt(); issue_wr(7'd30, 3'd3);
    expect_out("t4_i30", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_wr(7'd31, 3'd1); use_a = 1; src_a = 7'd30; flush = 1;
    expect_out("t4_flush", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_b = 1; src_b = 7'd31;
    expect_out("t4_flushed_rt", 0, 2'b00, 2'b00, 2'b00);

    // Latency clamp: 0 acts as 1, 7 acts as 6
    nxt(); issue_wr(7'd40, 3'd0);
    expect_out("t5_i40", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd40;
    expect_out("t5_lat0", 0, 2'b01, 2'b00, 2'b00);
    nxt(); issue_wr(7'd41, 3'd7);
    expect_out("t5_i41", 0, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      nxt(); issue_valid = 1; use_a = 1; src_a = 7'd41;
      expect_out($sformatf("t5_lat7_age%0d", i), 1, 2'b00, 2'b00, 2'b00, 1);
    end
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd41;
    expect_out("t5_lat7_ready", 0, 2'b01, 2'b00, 2'b00, 0, 1, 16'd6);

    // Not-ready source without issue_valid does not stall
    nxt(); issue_wr(7'd50, 3'd4);
    expect_out("t6_i50", 0, 2'b00, 2'b00, 2'b00);
    nxt(); use_a = 1; src_a = 7'd50;
    expect_out("t6_noissue", 0, 2'b00, 2'b00, 2'b00, 1, 1, 16'd6);

    // Self-dependent lat-6 writer of rt=1: stalls 5 of every 6 cycles
    for (int i = 0; i < 79000; i++) begin
      nxt(); issue_wr(7'd1, 3'd6); use_a = 1; src_a = 7'd1;
      if (i == 0)
        expect_out("t7_first", 0, 2'b00, 2'b00, 2'b00);
      else if (i < 6)
        expect_out($sformatf("t7_stall%0d", i), 1, 2'b00, 2'b00, 2'b00, 1);
      else if (i == 6)
        expect_out("t7_reissue", 0, 2'b01, 2'b00, 2'b00);
    end
    nxt();
    expect_out("t7_sat", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'hFFFF);

    // Asynchronous reset between edges with a pending hazard
    nxt(); issue_wr(7'd60, 3'd6);
    expect_out("t8_i60", 0, 2'b00, 2'b00, 2'b00);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd60;
    expect_out("t8_pending", 1, 2'b00, 2'b00, 2'b00, 1, 1, 16'hFFFF);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd60; reset = 1;
    expect_out("t8_rst_async", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h0);
    nxt(); issue_valid = 1; use_a = 1; src_a = 7'd60; reset = 0;
    expect_out("t8_no_stale", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h0);
    nxt();
    expect_out("t8_cnt", 0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h0);

    for (int i = 0; i < 10 && sbq.size() != 0; i++)
      @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending entries got %0d want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
